dm_arbiter: RTL and testbench
=============================

Name: dm_arbiter

Overview:
- Two-requester arbiter/sequencer in front of the data memory (DM); owns the DM Addr/WD/WE/LStype/InsAddr bus.
- Port A is the pipeline MEM stage. Port B is the debug/loader port.
- Arbitration is round-robin. Each transaction runs through a fixed IDLE→ISSUE→ACK sequence with registered operands and registered read data.
- Alignment, LStype and range errors are detected before DM is touched. An erroneous store never writes DM.

Parameters:
- ADDR_LIMIT, 32'h0000_1000, byte-address upper bound (exclusive); addresses ≥ ADDR_LIMIT are errors.
- B_INSADDR, 32'h0000_0000, value driven on dm_insaddr for port-B transactions.

Ports:
- clk  in  1  system clock, rising edge
- reset  in  1  synchronous, active-low: reset==0 at a rising clk edge resets the block
- a_req  in  1  port A request; held with operands stable until a_ack
- a_addr  in  32  port A byte address
- a_wdata  in  32  port A store data
- a_we  in  1  port A 1=store, 0=load
- a_lstype  in  3  port A access type (DM encoding)
- a_pc  in  32  port A instruction address, forwarded to dm_insaddr
- a_ack  out  1  one-cycle completion pulse for port A
- a_rdata  out  32  port A load data; valid while a_ack=1
- a_err  out  1  port A error flag; valid while a_ack=1
- a_stall  out  1  a_req & ~a_ack; freezes the pipeline
- b_req, b_addr, b_wdata, b_we, b_lstype  in  1/32/32/1/3  port B, same semantics as port A
- b_ack, b_rdata, b_err  out  1/32/1  port B, same semantics as port A
- dm_addr  out  32  to DM Addr
- dm_wd  out  32  to DM WD
- dm_we  out  1  to DM WE
- dm_lstype  out  3  to DM LStype
- dm_insaddr  out  32  to DM InsAddr
- dm_rd  in  32  from DM RD (combinational read)
- busy  out  1  1 when state≠IDLE

Behaviour:
- FSM states: IDLE, ISSUE, ACK. Reset (reset==0) forces IDLE and clears every output and internal register to 0; the round-robin pointer is set to favour A.
- Reset applied mid-transaction aborts it: no ack is given, and dm_we=0 from the reset edge onward.
- IDLE:
  - If no request is pending, stay in IDLE.
  - If one requester has req=1, grant it.
  - If both have req=1, grant the port the pointer favours.
  - On grant: latch addr, wdata, we, lstype and insaddr (a_pc or B_INSADDR); compute and latch err; go to ISSUE.
- Error computation (err=1 if any condition holds):
  - addr ≥ ADDR_LIMIT.
  - Store: lstype 000 requires addr[1:0]=00; 001 (sh) requires addr[0]=0; 010 (sb) is any alignment; any other lstype is an error.
  - Load: 000 requires addr[1:0]=00; 001/010 (lh/lhu) require addr[0]=0; 011/100 (lb/lbu) are any alignment; 101–111 are errors.
- ISSUE (exactly one cycle):
  - dm_addr, dm_wd, dm_lstype and dm_insaddr are driven from the latched operands.
  - dm_we = latched_we & ~err.
  - At the clock edge, the read-data register captures dm_rd if the access is a load with err=0, otherwise 0. Go to ACK.
- Outside ISSUE, dm_we=0 and dm_addr/dm_wd/dm_lstype/dm_insaddr are 0.
- ACK (exactly one cycle):
  - The granted port's ack=1, its rdata = registered data, its err = latched err. The other port's ack/rdata/err are 0.
  - The pointer flips to favour the port not just served. Go to IDLE.
- Latency: grant edge to ack is 2 cycles; sustained throughput is 1 transaction per 3 cycles.
- In ACK the served port's req is still high and is ignored. In IDLE a request is accepted on its first cycle high.
- Dropping req before ack is a protocol violation. The transaction still completes on the latched operands and ack is still pulsed.
- Starvation: with both ports continuously requesting, grants strictly alternate A, B, A, B…

Test Plan:
- Reset then single A store: a_req=1, addr 0x10, wdata 0xDEADBEEF, we=1, lstype 000.
  - dm_we=1 for exactly one cycle with dm_addr=0x10.
  - a_ack pulses 2 cycles after grant; a_err=0.
  - a_stall stays high until the ack cycle.
- A load after that store: lstype 001, addr 0x12 → a_rdata=0xFFFFDEAD. Same load with lstype 100, addr 0x10 → a_rdata=0x000000EF.
- Both ports request continuously from IDLE after reset:
  - Grant order is A, B, A, B.
  - Each ack appears 3 cycles apart, never for both ports in the same cycle.
- Errors:
  - A store word to 0x11 → a_err=1, dm_we never asserted, memory at 0x10 unchanged.
  - B load to 0x1000 → b_err=1, b_rdata=0.
  - B store with lstype 011 → b_err=1.
- Reset mid-operation: reset=0 during ISSUE of an A store → no a_ack, busy=0 next cycle. After reset is released, a fresh B request is granted first.
- Protocol violation: a_req deasserts after the grant edge → transaction completes on the latched operands and a_ack still pulses once.

Source files
------------

// File: rtl/dm_arbiter_if.sv
// dm_arbiter_if: requester ports A/B and the DM bus owned by the arbiter
interface dm_arbiter_if;
    logic        a_req;
    logic [31:0] a_addr;
    logic [31:0] a_wdata;
    logic        a_we;
    logic [2:0]  a_lstype;
    logic [31:0] a_pc;
    logic        a_ack;
    logic [31:0] a_rdata;
    logic        a_err;
    logic        a_stall;
    logic        b_req;
    logic [31:0] b_addr;
    logic [31:0] b_wdata;
    logic        b_we;
    logic [2:0]  b_lstype;
    logic        b_ack;
    logic [31:0] b_rdata;
    logic        b_err;
    logic [31:0] dm_addr;
    logic [31:0] dm_wd;
    logic        dm_we;
    logic [2:0]  dm_lstype;
    logic [31:0] dm_insaddr;
    logic [31:0] dm_rd;
    logic        busy;

    modport slave (
        input  a_req, a_addr, a_wdata, a_we, a_lstype, a_pc,
        input  b_req, b_addr, b_wdata, b_we, b_lstype,
        input  dm_rd,
        output a_ack, a_rdata, a_err, a_stall,
        output b_ack, b_rdata, b_err,
        output dm_addr, dm_wd, dm_we, dm_lstype, dm_insaddr,
        output busy
    );

    modport master (
        output a_req, a_addr, a_wdata, a_we, a_lstype, a_pc,
        output b_req, b_addr, b_wdata, b_we, b_lstype,
        output dm_rd,
        input  a_ack, a_rdata, a_err, a_stall,
        input  b_ack, b_rdata, b_err,
        input  dm_addr, dm_wd, dm_we, dm_lstype, dm_insaddr,
        input  busy
    );
endinterface

// File: rtl/dm_arbiter.sv
// dm_arbiter: round-robin two-port sequencer owning the data-memory bus
module dm_arbiter #(
    parameter logic [31:0] ADDR_LIMIT = 32'h0000_1000,
    parameter logic [31:0] B_INSADDR  = 32'h0000_0000
) (
    input  logic          clk,
    input  logic          reset,
    dm_arbiter_if.slave   bus
);
    typedef enum logic [1:0] {IDLE, ISSUE, ACK} state_t;

    state_t      state_q, state_d;
    logic        ptr_q, ptr_d;
    logic        sel_q, sel_d;
    logic        we_q, we_d;
    logic        err_q, err_d;
    logic [2:0]  lstype_q, lstype_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;
    logic [31:0] insaddr_q, insaddr_d;
    logic [31:0] rdata_q, rdata_d;
    logic        gnt_b;
    logic        issue;
    logic        acking;

    function automatic logic access_err(input logic [31:0] addr, input logic we, input logic [2:0] lstype);
        logic bad;
        if (we)
            bad = (lstype == 3'd0) ? (addr[1:0] != 2'b00) :
                  (lstype == 3'd1) ? addr[0] : (lstype != 3'd2);
        else
            bad = (lstype == 3'd0) ? (addr[1:0] != 2'b00) :
                  (lstype == 3'd1 || lstype == 3'd2) ? addr[0] :
                  !(lstype == 3'd3 || lstype == 3'd4);
        return bad | (addr >= ADDR_LIMIT);
    endfunction

    // next-state: grant and latch operands in IDLE, capture read data in ISSUE, flip pointer in ACK
    always_comb begin
        state_d   = state_q;
        ptr_d     = ptr_q;
        sel_d     = sel_q;
        we_d      = we_q;
        err_d     = err_q;
        lstype_d  = lstype_q;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        insaddr_d = insaddr_q;
        rdata_d   = rdata_q;
        gnt_b     = bus.b_req & (~bus.a_req | ptr_q);
        case (state_q)
            IDLE: begin
                if (bus.a_req | bus.b_req) begin
                    sel_d     = gnt_b;
                    addr_d    = gnt_b ? bus.b_addr   : bus.a_addr;
                    wdata_d   = gnt_b ? bus.b_wdata  : bus.a_wdata;
                    we_d      = gnt_b ? bus.b_we     : bus.a_we;
                    lstype_d  = gnt_b ? bus.b_lstype : bus.a_lstype;
                    insaddr_d = gnt_b ? B_INSADDR    : bus.a_pc;
                    err_d     = access_err(addr_d, we_d, lstype_d);
                    state_d   = ISSUE;
                end
            end
            ISSUE: begin
                rdata_d = (~we_q & ~err_q) ? bus.dm_rd : 32'h0;
                state_d = ACK;
            end
            ACK: begin
                ptr_d   = ~sel_q;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // state and operand registers, cleared by synchronous active-low reset
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q   <= IDLE;
            ptr_q     <= 1'b0;
            sel_q     <= 1'b0;
            we_q      <= 1'b0;
            err_q     <= 1'b0;
            lstype_q  <= 3'h0;
            addr_q    <= 32'h0;
            wdata_q   <= 32'h0;
            insaddr_q <= 32'h0;
            rdata_q   <= 32'h0;
        end else begin
            state_q   <= state_d;
            ptr_q     <= ptr_d;
            sel_q     <= sel_d;
            we_q      <= we_d;
            err_q     <= err_d;
            lstype_q  <= lstype_d;
            addr_q    <= addr_d;
            wdata_q   <= wdata_d;
            insaddr_q <= insaddr_d;
            rdata_q   <= rdata_d;
        end
    end

    // DM bus is live only in ISSUE; completion signals only for the served port in ACK
    always_comb begin
        issue          = (state_q == ISSUE);
        acking         = (state_q == ACK);
        bus.dm_addr    = issue ? addr_q    : 32'h0;
        bus.dm_wd      = issue ? wdata_q   : 32'h0;
        bus.dm_lstype  = issue ? lstype_q  : 3'h0;
        bus.dm_insaddr = issue ? insaddr_q : 32'h0;
        bus.dm_we      = issue & we_q & ~err_q;
        bus.a_ack      = acking & ~sel_q;
        bus.b_ack      = acking & sel_q;
        bus.a_rdata    = bus.a_ack ? rdata_q : 32'h0;
        bus.b_rdata    = bus.b_ack ? rdata_q : 32'h0;
        bus.a_err      = bus.a_ack & err_q;
        bus.b_err      = bus.b_ack & err_q;
        bus.a_stall    = bus.a_req & ~bus.a_ack;
        bus.busy       = (state_q != IDLE);
    end
endmodule

// File: tb/tb_dm_arbiter.sv
// tb_dm_arbiter: directed vectors, corner sequences and randomized scoreboard for dm_arbiter
module tb_dm_arbiter;
    localparam logic [31:0] LIMIT = 32'h0000_1000;
    localparam logic [31:0] BINS  = 32'h0000_B000;

    typedef struct packed {
        logic        port;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic        we;
        logic [2:0]  lst;
        logic        err;
        logic [31:0] rd;
    } vec_t;

    logic clk = 1'b0;
    logic reset = 1'b0;
    int checks = 0;
    int errors = 0;
    logic [7:0] mem [0:4095] = '{default: 8'h0};
    logic [7:0] ref_mem [0:4095];
    logic [31:0] dm_word;
    vec_t vt [17];

    dm_arbiter_if bus ();

    dm_arbiter #(.ADDR_LIMIT(LIMIT), .B_INSADDR(BINS)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] load_ext(input logic [31:0] w, input logic [1:0] lo, input logic [2:0] lst);
        logic [15:0] h;
        logic [7:0]  b;
        logic [31:0] r;
        h = lo[1] ? w[31:16] : w[15:0];
        b = w[8*lo +: 8];
        case (lst)
            3'd0: r = w;
            3'd1: r = {{16{h[15]}}, h};
            3'd2: r = {16'h0, h};
            3'd3: r = {{24{b[7]}}, b};
            3'd4: r = {24'h0, b};
            default: r = 32'h0;
        endcase
        return r;
    endfunction

    // data memory: combinational read, byte-lane write on the clock edge
    assign dm_word = {mem[{bus.dm_addr[11:2], 2'd3}], mem[{bus.dm_addr[11:2], 2'd2}],
                      mem[{bus.dm_addr[11:2], 2'd1}], mem[{bus.dm_addr[11:2], 2'd0}]};
    assign bus.dm_rd = load_ext(dm_word, bus.dm_addr[1:0], bus.dm_lstype);

    always @(posedge clk) begin
        if (bus.dm_we) begin
            case (bus.dm_lstype)
                3'd0: begin
                    mem[{bus.dm_addr[11:2], 2'd0}] <= bus.dm_wd[7:0];
                    mem[{bus.dm_addr[11:2], 2'd1}] <= bus.dm_wd[15:8];
                    mem[{bus.dm_addr[11:2], 2'd2}] <= bus.dm_wd[23:16];
                    mem[{bus.dm_addr[11:2], 2'd3}] <= bus.dm_wd[31:24];
                end
                3'd1: begin
                    mem[{bus.dm_addr[11:1], 1'b0}] <= bus.dm_wd[7:0];
                    mem[{bus.dm_addr[11:1], 1'b1}] <= bus.dm_wd[15:8];
                end
                3'd2: mem[bus.dm_addr[11:0]] <= bus.dm_wd[7:0];
                default: ;
            endcase
        end
    end

    function automatic logic [31:0] ref_word(input logic [31:0] a);
        int base;
        base = int'(a[11:0]) & ~3;
        return {ref_mem[base+3], ref_mem[base+2], ref_mem[base+1], ref_mem[base]};
    endfunction

    task automatic ref_store(input logic [31:0] a, input logic [31:0] d, input logic [2:0] lst);
        int n;
        int base;
        n = (lst == 3'd0) ? 4 : (lst == 3'd1) ? 2 : 1;
        base = int'(a[11:0]) & ~(n - 1);
        for (int i = 0; i < n; i++) ref_mem[base+i] = d[8*i +: 8];
    endtask

    function automatic logic ref_err(input logic [31:0] a, input logic we, input logic [2:0] lst);
        int st_al [8] = '{4, 2, 1, 0, 0, 0, 0, 0};
        int ld_al [8] = '{4, 2, 2, 1, 1, 0, 0, 0};
        int al;
        al = we ? st_al[lst] : ld_al[lst];
        return (a >= LIMIT) || (al == 0) || ((a % al) != 0);
    endfunction

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", name, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic rand_op(output logic [31:0] a, output logic [31:0] d, output logic we, output logic [2:0] lst);
        a   = ($urandom_range(0, 9) == 0) ? 32'h1000 + $urandom_range(0, 15) : 32'h100 + $urandom_range(0, 63);
        d   = $urandom;
        we  = 1'($urandom_range(0, 1));
        lst = 3'($urandom_range(0, 7));
    endtask

    task automatic run_single(input vec_t v, input int idx);
        logic [31:0] pc;
        pc = 32'h400 + 32'(idx * 4);
        if (!v.port) begin
            bus.a_req = 1'b1; bus.a_addr = v.addr; bus.a_wdata = v.wdata;
            bus.a_we = v.we; bus.a_lstype = v.lst; bus.a_pc = pc;
        end else begin
            bus.b_req = 1'b1; bus.b_addr = v.addr; bus.b_wdata = v.wdata;
            bus.b_we = v.we; bus.b_lstype = v.lst;
        end
        #1;
        chk($sformatf("v%0d stall_pre", idx), 32'(bus.a_stall), 32'(!v.port));
        tick;
        chk($sformatf("v%0d busy", idx), 32'(bus.busy), 32'd1);
        chk($sformatf("v%0d dm_we", idx), 32'(bus.dm_we), 32'(v.we & ~v.err));
        chk($sformatf("v%0d dm_addr", idx), bus.dm_addr, v.addr);
        chk($sformatf("v%0d dm_wd", idx), bus.dm_wd, v.wdata);
        chk($sformatf("v%0d dm_lstype", idx), 32'(bus.dm_lstype), 32'(v.lst));
        chk($sformatf("v%0d dm_insaddr", idx), bus.dm_insaddr, v.port ? BINS : pc);
        chk($sformatf("v%0d early_ack", idx), 32'(bus.a_ack | bus.b_ack), 32'd0);
        tick;
        chk($sformatf("v%0d a_ack", idx), 32'(bus.a_ack), 32'(!v.port));
        chk($sformatf("v%0d b_ack", idx), 32'(bus.b_ack), 32'(v.port));
        chk($sformatf("v%0d err", idx), 32'(v.port ? bus.b_err : bus.a_err), 32'(v.err));
        chk($sformatf("v%0d rdata", idx), v.port ? bus.b_rdata : bus.a_rdata, v.rd);
        chk($sformatf("v%0d stall_ack", idx), 32'(bus.a_stall), 32'd0);
        chk($sformatf("v%0d dm_we_ack", idx), 32'(bus.dm_we), 32'd0);
        bus.a_req = 1'b0;
        bus.b_req = 1'b0;
        tick;
        chk($sformatf("v%0d idle", idx), 32'(bus.busy | bus.a_ack | bus.b_ack), 32'd0);
    endtask

    initial begin
        logic [31:0] ra, rd_, e_addr, e_wd, e_ins, e_rd;
        logic rwe, e_we, e_err, ea, eb, mport, favor;
        logic [2:0] rls, e_lst;
        int st;

        bus.a_req = 0; bus.a_addr = 0; bus.a_wdata = 0; bus.a_we = 0; bus.a_lstype = 0; bus.a_pc = 0;
        bus.b_req = 0; bus.b_addr = 0; bus.b_wdata = 0; bus.b_we = 0; bus.b_lstype = 0;

        vt[0]  = '{1'b0, 32'h10,   32'hDEADBEEF, 1'b1, 3'd0, 1'b0, 32'h0};
        vt[1]  = '{1'b0, 32'h12,   32'h0,        1'b0, 3'd1, 1'b0, 32'hFFFFDEAD};
        vt[2]  = '{1'b0, 32'h10,   32'h0,        1'b0, 3'd4, 1'b0, 32'h000000EF};
        vt[3]  = '{1'b0, 32'h11,   32'h11111111, 1'b1, 3'd0, 1'b1, 32'h0};
        vt[4]  = '{1'b0, 32'h10,   32'h0,        1'b0, 3'd0, 1'b0, 32'hDEADBEEF};
        vt[5]  = '{1'b1, 32'h1000, 32'h0,        1'b0, 3'd0, 1'b1, 32'h0};
        vt[6]  = '{1'b1, 32'h20,   32'h55555555, 1'b1, 3'd3, 1'b1, 32'h0};
        vt[7]  = '{1'b1, 32'h22,   32'h00001234, 1'b1, 3'd1, 1'b0, 32'h0};
        vt[8]  = '{1'b1, 32'h20,   32'h0,        1'b0, 3'd0, 1'b0, 32'h12340000};
        vt[9]  = '{1'b0, 32'h21,   32'hFFFFFFAB, 1'b1, 3'd2, 1'b0, 32'h0};
        vt[10] = '{1'b0, 32'h21,   32'h0,        1'b0, 3'd3, 1'b0, 32'hFFFFFFAB};
        vt[11] = '{1'b0, 32'h20,   32'h0,        1'b0, 3'd0, 1'b0, 32'h1234AB00};
        vt[12] = '{1'b0, 32'h11,   32'h0,        1'b0, 3'd2, 1'b1, 32'h0};
        vt[13] = '{1'b0, 32'h20,   32'h0,        1'b0, 3'd5, 1'b1, 32'h0};
        vt[14] = '{1'b1, 32'h22,   32'h0,        1'b0, 3'd2, 1'b0, 32'h00001234};
        vt[15] = '{1'b0, 32'hFFC,  32'h0,        1'b0, 3'd0, 1'b0, 32'h0};
        vt[16] = '{1'b0, 32'h1000, 32'h000000AA, 1'b1, 3'd2, 1'b1, 32'h0};

        tick;
        tick;
        chk("rst busy", 32'(bus.busy), 32'd0);
        chk("rst acks", 32'(bus.a_ack | bus.b_ack), 32'd0);
        chk("rst dm_we", 32'(bus.dm_we), 32'd0);
        chk("rst dm_addr", bus.dm_addr, 32'h0);
        chk("rst rdata", bus.a_rdata | bus.b_rdata, 32'h0);
        chk("rst err", 32'(bus.a_err | bus.b_err), 32'd0);
        reset = 1'b1;
        tick;

        for (int i = 0; i < 17; i++) run_single(vt[i], i);

        // both ports continuously requesting right after reset: A, B, A, B every 3 cycles
        reset = 1'b0;
        tick;
        reset = 1'b1;
        bus.a_req = 1; bus.a_addr = 32'h10; bus.a_we = 0; bus.a_lstype = 3'd0;
        bus.b_req = 1; bus.b_addr = 32'h20; bus.b_we = 0; bus.b_lstype = 3'd0;
        for (int k = 1; k <= 12; k++) begin
            logic xa, xb;
            tick;
            xa = (k % 3 == 2) && ((k / 3) % 2 == 0);
            xb = (k % 3 == 2) && ((k / 3) % 2 == 1);
            chk($sformatf("rr a_ack c%0d", k), 32'(bus.a_ack), 32'(xa));
            chk($sformatf("rr b_ack c%0d", k), 32'(bus.b_ack), 32'(xb));
            if (xa) chk($sformatf("rr a_rdata c%0d", k), bus.a_rdata, 32'hDEADBEEF);
            if (xb) chk($sformatf("rr b_rdata c%0d", k), bus.b_rdata, 32'h1234AB00);
        end
        bus.a_req = 0;
        bus.b_req = 0;
        tick;
        tick;

        // reset during ISSUE of an A store aborts it; B is then served alone
        bus.a_req = 1; bus.a_addr = 32'h30; bus.a_wdata = 32'h77; bus.a_we = 1; bus.a_lstype = 3'd0;
        tick;
        chk("mid dm_we issue", 32'(bus.dm_we), 32'd1);
        reset = 1'b0;
        tick;
        chk("mid busy", 32'(bus.busy), 32'd0);
        chk("mid dm_we", 32'(bus.dm_we), 32'd0);
        chk("mid a_ack", 32'(bus.a_ack), 32'd0);
        bus.a_req = 0;
        tick;
        chk("mid a_ack2", 32'(bus.a_ack), 32'd0);
        reset = 1'b1;
        bus.b_req = 1; bus.b_addr = 32'h10; bus.b_we = 0; bus.b_lstype = 3'd0;
        tick;
        chk("mid b grant", 32'(bus.busy), 32'd1);
        chk("mid b insaddr", bus.dm_insaddr, BINS);
        tick;
        chk("mid b_ack", 32'(bus.b_ack), 32'd1);
        chk("mid b_rdata", bus.b_rdata, 32'hDEADBEEF);
        bus.b_req = 0;
        tick;

        // A drops req after grant: completes on latched operands, one ack
        bus.a_req = 1; bus.a_addr = 32'h10; bus.a_we = 0; bus.a_lstype = 3'd0;
        tick;
        bus.a_req = 0;
        bus.a_addr = 32'h20;
        tick;
        chk("pv a_ack", 32'(bus.a_ack), 32'd1);
        chk("pv a_rdata", bus.a_rdata, 32'hDEADBEEF);
        chk("pv stall", 32'(bus.a_stall), 32'd0);
        tick;
        chk("pv single ack", 32'(bus.a_ack), 32'd0);
        chk("pv idle", 32'(bus.busy), 32'd0);

        // randomized traffic against a transaction-level scoreboard
        reset = 1'b0;
        tick;
        reset = 1'b1;
        for (int i = 0; i < 4096; i++) ref_mem[i] = mem[i];
        st = 0;
        favor = 1'b0;
        mport = 1'b0;
        e_addr = 0; e_wd = 0; e_ins = 0; e_rd = 0; e_we = 0; e_err = 0; e_lst = 0;
        for (int c = 0; c < 900; c++) begin
            if (!bus.a_req && $urandom_range(0, 1) == 1) begin
                rand_op(ra, rd_, rwe, rls);
                bus.a_addr = ra; bus.a_wdata = rd_; bus.a_we = rwe; bus.a_lstype = rls;
                bus.a_pc = $urandom; bus.a_req = 1;
            end
            if (!bus.b_req && $urandom_range(0, 1) == 1) begin
                rand_op(ra, rd_, rwe, rls);
                bus.b_addr = ra; bus.b_wdata = rd_; bus.b_we = rwe; bus.b_lstype = rls;
                bus.b_req = 1;
            end
            ea = bus.a_req;
            eb = bus.b_req;
            tick;
            chk("rnd stall", 32'(bus.a_stall), 32'(ea && !(st == 1 && !mport)));
            if (st == 0) begin
                if (ea || eb) begin
                    mport  = (ea && eb) ? favor : eb;
                    e_addr = mport ? bus.b_addr   : bus.a_addr;
                    e_wd   = mport ? bus.b_wdata  : bus.a_wdata;
                    e_we   = mport ? bus.b_we     : bus.a_we;
                    e_lst  = mport ? bus.b_lstype : bus.a_lstype;
                    e_ins  = mport ? BINS         : bus.a_pc;
                    e_err  = ref_err(e_addr, e_we, e_lst);
                    e_rd   = (!e_we && !e_err) ? load_ext(ref_word(e_addr), e_addr[1:0], e_lst) : 32'h0;
                    if (e_we && !e_err) ref_store(e_addr, e_wd, e_lst);
                    chk("rnd busy", 32'(bus.busy), 32'd1);
                    chk("rnd dm_we", 32'(bus.dm_we), 32'(e_we && !e_err));
                    chk("rnd dm_addr", bus.dm_addr, e_addr);
                    chk("rnd dm_wd", bus.dm_wd, e_wd);
                    chk("rnd dm_lstype", 32'(bus.dm_lstype), 32'(e_lst));
                    chk("rnd dm_insaddr", bus.dm_insaddr, e_ins);
                    st = 1;
                end else begin
                    chk("rnd idle busy", 32'(bus.busy), 32'd0);
                end
            end else if (st == 1) begin
                chk("rnd a_ack", 32'(bus.a_ack), 32'(!mport));
                chk("rnd b_ack", 32'(bus.b_ack), 32'(mport));
                chk("rnd err", 32'(mport ? bus.b_err : bus.a_err), 32'(e_err));
                chk("rnd rdata", mport ? bus.b_rdata : bus.a_rdata, e_rd);
                chk("rnd other", mport ? bus.a_rdata : bus.b_rdata, 32'h0);
                favor = !mport;
                if (mport) bus.b_req = 0;
                else bus.a_req = 0;
                st = 2;
            end else begin
                chk("rnd post busy", 32'(bus.busy), 32'd0);
                chk("rnd post acks", 32'(bus.a_ack | bus.b_ack), 32'd0);
                st = 0;
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
